// File: rtl/muldiv_seq_if.sv
// Handshake and data bundle for the sequential multiply/divide unit.
// The master side issues operations and register writes; the slave side returns status and HI/LO.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// MIPS-style iterative multiply/divide: magnitudes are processed one bit per cycle,
// signs are restored in a single fix-up cycle before HI/LO are written.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] work_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               is_div_reg, sign_a_reg, sign_b_reg, zero_div_reg, dbz_reg;
    logic               accept;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    // Unsigned WIDTH-bit magnitude keeps the most negative operand representable.
    assign is_signed = ~bus.op[0];
    assign mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign add_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, (work_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    assign mul_next = {add_sum, work_reg[WIDTH-1:1]};

    // Trial subtraction on the shifted partial remainder; a borrow restores it.
    assign trial    = work_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
    assign div_next = trial[WIDTH] ? {work_reg[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};

    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -work_reg : work_reg;
    assign rem_fix  = sign_a_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];
    assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                bus.done   = (state_reg == DONE);
                accept     = bus.start;
                state_next = bus.start ? CALC : IDLE;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (count_reg == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                bus.busy   = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            work_reg     <= '0;
            opnd_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div_reg   <= 1'b0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            zero_div_reg <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        work_reg     <= {{WIDTH{1'b0}}, mag_a};
                        opnd_reg     <= mag_b;
                        count_reg    <= '0;
                        is_div_reg   <= bus.op[1];
                        sign_a_reg   <= is_signed & bus.a[WIDTH-1];
                        sign_b_reg   <= is_signed & bus.b[WIDTH-1];
                        zero_div_reg <= bus.op[1] && (bus.b == '0);
                        dbz_reg      <= 1'b0;
                    end else begin
                        if (bus.wr_hi) hi_reg <= bus.wdata;
                        if (bus.wr_lo) lo_reg <= bus.wdata;
                    end
                end
                CALC: begin
                    work_reg  <= is_div_reg ? div_next : mul_next;
                    count_reg <= count_reg + CW'(1);
                end
                FIX: begin
                    if (is_div_reg) begin
                        // A zero divisor leaves the dividend in the remainder; the quotient is forced.
                        hi_reg  <= rem_fix;
                        lo_reg  <= zero_div_reg ? {WIDTH{1'b1}} : quo_fix;
                        dbz_reg <= zero_div_reg;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values even, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend (rs).
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor (rt).
REQ-008 SHALL have port wr_hi  input  1  direct HI write (mthi).
REQ-009 SHALL have port wr_lo  input  1  direct LO write (mtlo).
REQ-010 SHALL have port wdata  input  WIDTH  data for wr_hi/wr_lo.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse: HI/LO hold the new result.
REQ-013 SHALL have port div_by_zero  output  1  last div/divu had b==0.
REQ-014 SHALL have port hi  output  WIDTH  HI register (product high half / remainder).
REQ-015 SHALL have port lo  output  WIDTH  LO register (product low half / quotient).

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-017 Transitions SHALL be: IDLE/DONE + start -> CALC; IDLE/DONE without start -> IDLE; CALC -> FIX after WIDTH iterations; FIX -> DONE.
REQ-018 On accepting start, SHALL latch op and operand magnitudes (absolute value for signed ops), record operand signs, and clear the iteration counter.
REQ-019 CALC SHALL perform one iteration per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide, on a 2*WIDTH-bit working register.
REQ-020 FIX SHALL apply sign correction and write HI/LO: mult product negated iff sign(a)^sign(b); div quotient negated iff sign(a)^sign(b), remainder sign = sign(a).
REQ-021 Latency SHALL be fixed: start sampled at edge E0, HI/LO updated at edge E(WIDTH+1), done=1 for exactly the following cycle.
REQ-022 busy SHALL be 1 in CALC and FIX, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-023 start while busy SHALL be ignored with no effect on the running operation.
REQ-024 start in DONE SHALL be accepted, so back-to-back operations complete every WIDTH+2 cycles.
REQ-025 HI/LO SHALL hold their value in CALC; the only updates are at FIX or via wr_hi/wr_lo.
REQ-026 wr_hi/wr_lo in IDLE or DONE SHALL load wdata into HI/LO at the next edge.
REQ-027 wr_hi/wr_lo while busy, or in the same cycle as an accepted start, SHALL be discarded.
REQ-028 div/divu with b==0 SHALL keep the same latency and produce hi=a, lo=all ones, div_by_zero=1.
REQ-029 div_by_zero SHALL be cleared at every accepted start and set only at FIX of a zero-divisor division.
REQ-030 div of the most negative value by -1 SHALL wrap: lo=most negative value, hi=0, div_by_zero=0.
REQ-031 Signed magnitude logic SHALL handle the most negative operand with WIDTH-bit unsigned magnitude (no overflow).
REQ-032 The iteration counter SHALL be clog2(WIDTH)+1 bits wide and SHALL not wrap within an operation.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE with hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, from any state.
REQ-034 reset mid-operation SHALL abort with no done pulse and no HI/LO result write.
REQ-035 reset SHALL take priority over start, wr_hi and wr_lo in the same cycle.

Verification (WIDTH=32)
REQ-036 mult a=0xFFFFFFFF, b=2 -> done one cycle after edge E33; hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for 33 cycles.
REQ-037 multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-038 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; same inputs as divu -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-039 divu a=0x80000000, b=0 -> hi=0x80000000, lo=0xFFFFFFFF, div_by_zero=1; following mult start -> div_by_zero=0 at edge E0.
REQ-040 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; second start plus wr_lo pulses during the run -> both ignored.
REQ-041 reset at cycle 10 of divu -> next cycle busy=0, hi=lo=0, no done ever; wr_hi=1, wdata=0x1234 in IDLE -> hi=0x00001234 at next edge.
